mont_mul_r4: RTL

Parametrised radix-4 Montgomery multiplier. It computes result = A·B·2^-N mod M for an odd modulus M and operands A, B < M. It is the next generation of the fixed 1024-bit multiplier: width is a parameter, it has a start/busy/done handshake, it captures its inputs at start, and it applies one final conditional subtraction. It sits under the RSA exponentiation controller, which issues one multiply per start.

---
 rtl/mont_pkg.sv | 38 +++
 rtl/mont_addsub.sv | 27 ++
 rtl/mont_mul_r4.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/mont_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : mont_pkg                                               |
// | Description : Shared constants, state encoding and digit helpers for |
// |               the radix-4 Montgomery multiplier.                     |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
package mont_pkg;

  // Operand width used when the parent does not override N.
  localparam int unsigned c_N_DEFAULT = 1024;

  // Controller state encoding.
  localparam int unsigned c_ST_W = 3;
  typedef logic [c_ST_W-1:0] state_t;

  localparam state_t c_ST_IDLE  = 3'd0;
  localparam state_t c_ST_PRE   = 3'd1;
  localparam state_t c_ST_PRE3  = 3'd2;
  localparam state_t c_ST_ADD_B = 3'd3;
  localparam state_t c_ST_ADD_M = 3'd4;
  localparam state_t c_ST_FINAL = 3'd5;
  localparam state_t c_ST_DONE  = 3'd6;

  // (-M^-1) mod 4 for odd M: low bits 01 give 3, 11 give 1.
  function automatic logic [1:0] mp_of(input logic [1:0] m_lo);
    return {~m_lo[1], m_lo[0]};
  endfunction

  // Quotient digit that clears the two low bits of the accumulator.
  function automatic logic [1:0] q_of(input logic [1:0] c_lo, input logic [1:0] mp);
    logic [3:0] w_prod;
    w_prod = {2'b00, c_lo} * {2'b00, mp};
    return w_prod[1:0];
  endfunction

endpackage
`default_nettype wire

// File: rtl/mont_addsub.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : mont_addsub                                            |
// | Description : W-bit combinational adder/subtractor. co_o is the      |
// |               carry out; when subtracting, co_o=1 means no borrow.   |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module mont_addsub #(
  parameter int W = 8
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  input  logic         sub_i,
  output logic [W-1:0] sum_o,
  output logic         co_o
);

  logic [W-1:0] w_b;

  // Two's-complement add: subtraction inverts b and injects a carry.
  always_comb begin
    w_b           = sub_i ? ~b_i : b_i;
    {co_o, sum_o} = {1'b0, a_i} + {1'b0, w_b} + {{W{1'b0}}, sub_i};
  end

endmodule
`default_nettype wire

// File: rtl/mont_mul_r4.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : mont_mul_r4                                            |
// | Description : Radix-4 Montgomery multiplier, result = A*B*2^-N mod M |
// |               with start/busy/done handshake and fixed N+4 latency.  |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module mont_mul_r4
  import mont_pkg::*;
#(
  parameter int N = c_N_DEFAULT
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [N-1:0] in_a,
  input  logic [N-1:0] in_b,
  input  logic [N-1:0] in_m,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] result
);

  localparam int W  = N + 3;
  localparam int CW = $clog2(N/2 + 1);
  localparam logic [CW-1:0] c_LAST_DIGIT = CW'(N/2 - 1);

  state_t        state_q, state_d;
  logic [N-1:0]  a_q, a_d, b_q, b_d, m_q, m_d;
  logic [N+1:0]  b3_q, b3_d, m3_q, m3_d;
  logic [W-1:0]  c_q, c_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    mp_q, mp_d;
  logic [N-1:0]  result_q, result_d;
  logic          busy_q, done_q;

  logic [N+1:0]  w_mul_b, w_mul_m;
  logic [W-1:0]  w_op_a, w_op_b, w_sum;
  logic          w_sub, w_co;
  logic [1:0]    w_q;

  assign w_q = q_of(c_q[1:0], mp_q);

  // Digit multiple selection; 2B and 2M are plain shifts, only 3B/3M are stored.
  always_comb begin
    case (a_q[1:0])
      2'd0:    w_mul_b = '0;
      2'd1:    w_mul_b = {2'b00, b_q};
      2'd2:    w_mul_b = {1'b0, b_q, 1'b0};
      default: w_mul_b = b3_q;
    endcase
    case (w_q)
      2'd0:    w_mul_m = '0;
      2'd1:    w_mul_m = {2'b00, m_q};
      2'd2:    w_mul_m = {1'b0, m_q, 1'b0};
      default: w_mul_m = m3_q;
    endcase
  end

  // Operand steering for the single shared adder: PRE forms 3B, PRE3 forms 3M.
  always_comb begin
    w_op_a = c_q;
    w_op_b = '0;
    w_sub  = 1'b0;
    case (state_q)
      c_ST_PRE: begin
        w_op_a = {3'b000, b_q};
        w_op_b = {2'b00, b_q, 1'b0};
      end
      c_ST_PRE3: begin
        w_op_a = {3'b000, m_q};
        w_op_b = {2'b00, m_q, 1'b0};
      end
      c_ST_ADD_B: w_op_b = {1'b0, w_mul_b};
      c_ST_ADD_M: w_op_b = {1'b0, w_mul_m};
      c_ST_FINAL: begin
        w_op_b = {3'b000, m_q};
        w_sub  = 1'b1;
      end
      default: ;
    endcase
  end

  mont_addsub #(.W(W)) u_addsub (
    .a_i   (w_op_a),
    .b_i   (w_op_b),
    .sub_i (w_sub),
    .sum_o (w_sum),
    .co_o  (w_co)
  );

  // Controller and datapath next-state.
  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    m_d      = m_q;
    b3_d     = b3_q;
    m3_d     = m3_q;
    c_d      = c_q;
    cnt_d    = cnt_q;
    mp_d     = mp_q;
    result_d = result_q;
    case (state_q)
      c_ST_IDLE: begin
        if (start) begin
          a_d     = in_a;
          b_d     = in_b;
          m_d     = in_m;
          c_d     = '0;
          cnt_d   = '0;
          mp_d    = mp_of(in_m[1:0]);
          state_d = c_ST_PRE;
        end
      end
      c_ST_PRE: begin
        b3_d    = w_sum[N+1:0];
        state_d = c_ST_PRE3;
      end
      c_ST_PRE3: begin
        m3_d    = w_sum[N+1:0];
        state_d = c_ST_ADD_B;
      end
      c_ST_ADD_B: begin
        c_d     = w_sum;
        a_d     = {2'b00, a_q[N-1:2]};
        state_d = c_ST_ADD_M;
      end
      c_ST_ADD_M: begin
        // Low two bits of the sum are zero by choice of q; keep the carry.
        c_d     = {1'b0, w_co, w_sum[W-1:2]};
        cnt_d   = cnt_q + 1'b1;
        state_d = (cnt_q == c_LAST_DIGIT) ? c_ST_FINAL : c_ST_ADD_B;
      end
      c_ST_FINAL: begin
        // No borrow means C >= M, so the reduced value is C - M.
        result_d = w_co ? w_sum[N-1:0] : c_q[N-1:0];
        state_d  = c_ST_DONE;
      end
      c_ST_DONE: state_d = c_ST_IDLE;
      default:   state_d = c_ST_IDLE;
    endcase
  end

  // State registers; outputs are derived from the next state so they are registered.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= c_ST_IDLE;
      a_q      <= '0;
      b_q      <= '0;
      m_q      <= '0;
      b3_q     <= '0;
      m3_q     <= '0;
      c_q      <= '0;
      cnt_q    <= '0;
      mp_q     <= '0;
      result_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      m_q      <= m_d;
      b3_q     <= b3_d;
      m3_q     <= m3_d;
      c_q      <= c_d;
      cnt_q    <= cnt_d;
      mp_q     <= mp_d;
      result_q <= result_d;
      busy_q   <= (state_d != c_ST_IDLE);
      done_q   <= (state_d == c_ST_DONE);
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;

endmodule
`default_nettype wire
